// File: rtl/vga_pkg.sv
// Shared timing constants, capture states and pixel type for the VGA capture path.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [1:0] cap_state_t;
  localparam cap_state_t SEEK   = 2'd0;
  localparam cap_state_t ARMED  = 2'd1;
  localparam cap_state_t ACTIVE = 2'd2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Input register stage for the VGA link plus edge pulses on hsync, vsync and blank_n.
module vga_sync_edge
  import vga_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  pixel_t pix_in,
  input  logic   hsync,
  input  logic   vsync,
  input  logic   sync_n,
  input  logic   blank_n,
  input  logic   capture_en,
  input  logic   fifo_full,
  output pixel_t pix,
  output logic   hs,
  output logic   vs,
  output logic   csync_n,
  output logic   blank,
  output logic   en,
  output logic   full,
  output logic   valid,
  output logic   hs_fall,
  output logic   vs_rise,
  output logic   vs_fall,
  output logic   blank_rise,
  output logic   blank_fall
);

  pixel_t pix_q;
  logic   hs_q, vs_q, csync_q, blank_q, en_q, full_q, valid_q;
  logic   hs_prev_q, vs_prev_q, blank_prev_q, prev_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q        <= '0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      csync_q      <= 1'b0;
      blank_q      <= 1'b0;
      en_q         <= 1'b0;
      full_q       <= 1'b0;
      valid_q      <= 1'b0;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      blank_prev_q <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      pix_q        <= pix_in;
      hs_q         <= hsync;
      vs_q         <= vsync;
      csync_q      <= sync_n;
      blank_q      <= blank_n;
      en_q         <= capture_en;
      full_q       <= fifo_full;
      valid_q      <= 1'b1;
      hs_prev_q    <= hs_q;
      vs_prev_q    <= vs_q;
      blank_prev_q <= blank_q;
      prev_valid_q <= valid_q;
    end
  end

  assign pix     = pix_q;
  assign hs      = hs_q;
  assign vs      = vs_q;
  assign csync_n = csync_q;
  assign blank   = blank_q;
  assign en      = en_q;
  assign full    = full_q;
  assign valid   = valid_q;

  // Edges only count once both samples are real; the zeros left by reset would fake a rise.
  assign hs_fall    = prev_valid_q & hs_prev_q & ~hs_q;
  assign vs_rise    = prev_valid_q & ~vs_prev_q & vs_q;
  assign vs_fall    = prev_valid_q & vs_prev_q & ~vs_q;
  assign blank_rise = prev_valid_q & ~blank_prev_q & blank_q;
  assign blank_fall = prev_valid_q & blank_prev_q & ~blank_q;

endmodule

// File: rtl/vga_capture.sv
// VGA receive end: locks to frame timing, writes active pixels to a FIFO and flags errors.
module vga_capture
  import vga_pkg::*;
#(
  parameter int unsigned HActive = H_ACTIVE,
  parameter int unsigned HTotal  = H_TOTAL,
  parameter int unsigned VActive = V_ACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        sync_n,
  input  logic        blank_n,
  input  logic        capture_en,
  input  logic        fifo_full,
  input  logic        err_clr,
  output logic        fifo_wreq,
  output logic [25:0] fifo_wdata,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        err_timing,
  output logic        err_sync_n,
  output logic        err_overflow
);

  localparam logic [9:0]  XEnd  = 10'(HActive);
  localparam logic [9:0]  XLast = 10'(HActive - 1);
  localparam logic [9:0]  YEnd  = 10'(VActive);
  localparam logic [11:0] PEnd  = 12'(HTotal);

  pixel_t pix_raw, pix_s;
  logic   hs_s, vs_s, csync_s, blank_s, en_s, full_s, valid_s;
  logic   hs_fall, vs_rise, vs_fall, blank_rise, blank_fall;

  assign pix_raw = '{r: red, g: green, b: blue};

  vga_sync_edge u_sync_edge (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_raw),
    .hsync      (hsync),
    .vsync      (vsync),
    .sync_n     (sync_n),
    .blank_n    (blank_n),
    .capture_en (capture_en),
    .fifo_full  (fifo_full),
    .pix        (pix_s),
    .hs         (hs_s),
    .vs         (vs_s),
    .csync_n    (csync_s),
    .blank      (blank_s),
    .en         (en_s),
    .full       (full_s),
    .valid      (valid_s),
    .hs_fall    (hs_fall),
    .vs_rise    (vs_rise),
    .vs_fall    (vs_fall),
    .blank_rise (blank_rise),
    .blank_fall (blank_fall)
  );

  cap_state_t  state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d, y_inc;
  logic [11:0] period_q, period_d;
  logic        period_run_q, period_run_d;
  logic        wreq_q, wreq_d, done_q, done_d;
  logic [25:0] wdata_q, wdata_d;
  logic [15:0] fcount_q, fcount_d;
  logic        err_tim_q, err_tim_d, err_syn_q, err_syn_d, err_ovf_q, err_ovf_d;

  logic [9:0]  cur_x, line_y;
  logic        is_locked, pixel_ok, overflow_hit, sync_hit, timing_hit;

  assign is_locked    = (state_q == ARMED) || (state_q == ACTIVE);
  // The first pixel of a line arrives together with the blank_n rise, so x restarts there.
  assign cur_x        = blank_rise ? 10'd0 : x_q;
  assign line_y       = (state_q == ARMED) ? 10'd0 : y_q;
  assign y_inc        = y_q + 10'd1;
  assign pixel_ok     = blank_s && ((state_q == ACTIVE) || ((state_q == ARMED) && blank_rise));
  assign overflow_hit = pixel_ok && full_s;
  assign sync_hit     = valid_s && (csync_s != (hs_s ^ vs_s));

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    period_d     = period_q;
    period_run_d = period_run_q;
    wreq_d       = 1'b0;
    wdata_d      = wdata_q;
    done_d       = 1'b0;
    fcount_d     = fcount_q;
    timing_hit   = 1'b0;

    if (pixel_ok) begin
      x_d = (cur_x == 10'h3FF) ? cur_x : cur_x + 10'd1;
      if (!full_s) begin
        wreq_d  = 1'b1;
        wdata_d = {(cur_x == 10'd0) && (line_y == 10'd0), cur_x == XLast, pix_s};
      end
    end

    case (state_q)
      SEEK: begin
        if (en_s && vs_rise) state_d = ARMED;
      end
      ARMED: begin
        if (blank_rise) begin
          state_d = ACTIVE;
          y_d     = 10'd0;
        end
      end
      ACTIVE: begin
        if (vs_fall) begin
          timing_hit = 1'b1;
          state_d    = SEEK;
        end else if (blank_fall) begin
          if (x_q != XEnd) timing_hit = 1'b1;
          y_d = y_inc;
          if (y_inc == YEnd) begin
            done_d   = 1'b1;
            fcount_d = fcount_q + 16'd1;
            state_d  = SEEK;
          end
        end
      end
      default: state_d = SEEK;
    endcase

    // Line period is only judged between two hsync falls seen while locked.
    if (!is_locked) begin
      period_run_d = 1'b0;
      period_d     = 12'd0;
    end else if (hs_fall) begin
      if (period_run_q && (period_q != PEnd)) timing_hit = 1'b1;
      period_run_d = 1'b1;
      period_d     = 12'd1;
    end else if (period_q != 12'hFFF) begin
      period_d = period_q + 12'd1;
    end

    err_tim_d = timing_hit | (err_tim_q & ~err_clr);
    err_syn_d = sync_hit | (err_syn_q & ~err_clr);
    err_ovf_d = overflow_hit | (err_ovf_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEEK;
      x_q          <= '0;
      y_q          <= '0;
      period_q     <= '0;
      period_run_q <= 1'b0;
      wreq_q       <= 1'b0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      fcount_q     <= '0;
      err_tim_q    <= 1'b0;
      err_syn_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      period_q     <= period_d;
      period_run_q <= period_run_d;
      wreq_q       <= wreq_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      fcount_q     <= fcount_d;
      err_tim_q    <= err_tim_d;
      err_syn_q    <= err_syn_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign fifo_wreq    = wreq_q;
  assign fifo_wdata   = wdata_q;
  assign locked       = is_locked;
  assign frame_done   = done_q;
  assign frame_count  = fcount_q;
  assign err_timing   = err_tim_q;
  assign err_sync_n   = err_syn_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a scaled-down frame (16x6 active, 24x10 total).
module tb_vga_capture;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSY = 4;
  localparam int HBP = 2;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSY = 2;
  localparam int VBP = 1;
  localparam int VT  = VA + VFP + VSY + VBP;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, sync_n, blank_n, capture_en, fifo_full, err_clr;
  logic        fifo_wreq;
  logic [25:0] fifo_wdata;
  logic        locked, frame_done;
  logic [15:0] frame_count;
  logic        err_timing, err_sync_n, err_overflow;

  always #5 clk = ~clk;

  vga_capture #(
    .HActive (HA),
    .HTotal  (HT),
    .VActive (VA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .hsync        (hsync),
    .vsync        (vsync),
    .sync_n       (sync_n),
    .blank_n      (blank_n),
    .capture_en   (capture_en),
    .fifo_full    (fifo_full),
    .err_clr      (err_clr),
    .fifo_wreq    (fifo_wreq),
    .fifo_wdata   (fifo_wdata),
    .locked       (locked),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .err_timing   (err_timing),
    .err_sync_n   (err_sync_n),
    .err_overflow (err_overflow)
  );

  // One frame of stimulus plus what the frame should produce; -1 disables a fault field.
  typedef struct {
    int start_line;
    int en;
    int full_lo;
    int full_hi;
    int short_px;
    int short_clk;
    int rst_px;
    int bad_px;
    int rnd;
    int exp_wr;
    int exp_done;
    int exp_tim;
    int exp_ovf;
    int exp_syn;
  } vec_t;

  vec_t        tbl[8];
  int          n_tests, n_fail, n_wr, n_done, model_fc, pix_ctr;
  bit          armed;
  logic [25:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score anything the DUT emitted.
  task automatic step();
    logic [25:0] e;
    @(negedge clk);
    if (fifo_wreq) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got wdata 0x%0h, expected no write", fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        check("pixel", 32'(fifo_wdata), 32'(e));
      end
    end
    if (frame_done) n_done++;
  endtask

  task automatic gen_frame(input vec_t c, output int pushed, output bit ovf, output bit done);
    int          cyc, rst_cyc, bad_cyc, len, alen, idx;
    bit          act, full, hs, vs, bad, pushed_prev;
    logic [7:0]  col;
    logic [25:0] e;
    pushed = 0; ovf = 0; done = 0; pushed_prev = 0;
    cyc = 0; rst_cyc = -10; bad_cyc = -10;
    for (int v = c.start_line; v < VT; v++) begin
      len  = (v == c.short_clk) ? HT - 1 : HT;
      alen = (v == c.short_px) ? HA - 1 : HA;
      for (int h = 0; h < len; h++) begin
        step();
        if (cyc == 1)
          check("err_clr_flags", 32'({err_timing, err_sync_n, err_overflow}), 32'd0);
        if (cyc == rst_cyc + 1)
          check("mid_frame_reset", 32'({fifo_wreq, locked, frame_done, err_timing, err_sync_n,
                                       err_overflow, frame_count}), 32'd0);
        if (cyc == bad_cyc + 2) check("sync_err_beats_clr", 32'(err_sync_n), 32'd1);

        idx  = v * HA + h;
        act  = (v < VA) && (h < alen);
        hs   = !((h >= HA + HFP) && (h < HA + HFP + HSY));
        vs   = !((v >= VA + VFP) && (v < VA + VFP + VSY));
        full = act && ((c.rnd != 0) ? ($urandom_range(7) == 0)
                                    : (idx >= c.full_lo && idx <= c.full_hi));
        bad  = act && (idx == c.bad_px);
        col  = (c.rnd != 0) ? 8'($urandom) : 8'(pix_ctr);
        if (act) pix_ctr++;
        if (bad) bad_cyc = cyc;

        rst = act && (idx == c.rst_px);
        if (rst) begin
          // The pixel already in the input stage is lost along with everything after it.
          if (pushed_prev) begin
            void'(exp_q.pop_back());
            pushed--;
          end
          armed    = 0;
          model_fc = 0;
          rst_cyc  = cyc;
        end

        pushed_prev = 0;
        if (act && armed) begin
          if (full) ovf = 1;
          else begin
            e = {(v == 0) && (h == 0), h == HA - 1, col, col, col};
            exp_q.push_back(e);
            pushed++;
            pushed_prev = 1;
          end
          if ((v == VA - 1) && (h == alen - 1)) done = 1;
        end

        red       = col;
        green     = col;
        blue      = col;
        hsync     = hs;
        vsync     = vs;
        sync_n    = hs ^ vs ^ bad;
        blank_n   = act;
        fifo_full = full;
        err_clr   = (cyc == 0) || (cyc == bad_cyc + 1);
        cyc++;
      end
    end
    if (done) model_fc++;
    armed = (c.en != 0);
  endtask

  task automatic run_row(input vec_t c);
    int wr0, dn0, pushed;
    bit ovf, done;
    wr0 = n_wr;
    dn0 = n_done;
    capture_en = (c.en != 0);
    gen_frame(c, pushed, ovf, done);
    check("write_count", 32'(n_wr - wr0), 32'((c.rnd != 0) ? pushed : c.exp_wr));
    check("frame_done_count", 32'(n_done - dn0), 32'((c.rnd != 0) ? int'(done) : c.exp_done));
    check("err_timing", 32'(err_timing), 32'(c.exp_tim));
    check("err_overflow", 32'(err_overflow), 32'((c.rnd != 0) ? int'(ovf) : c.exp_ovf));
    check("err_sync_n", 32'(err_sync_n), 32'(c.exp_syn));
    check("frame_count", 32'(frame_count), 32'(model_fc & 16'hFFFF));
    check("locked", 32'(locked), 32'(c.en));
    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    vec_t r;
    n_tests = 0; n_fail = 0; n_wr = 0; n_done = 0;
    model_fc = 0; pix_ctr = 0; armed = 0;

    //          start en  flo fhi  spx sclk rst bad rnd  wr done tim ovf syn
    tbl[0] = '{3, 1, -1, -1, -1, -1, -1, -1, 0,  0, 0, 0, 0, 0};  // mid-frame start
    tbl[1] = '{0, 1, -1, -1, -1, -1, -1, -1, 0, 96, 1, 0, 0, 0};  // clean frame
    tbl[2] = '{0, 1, 52, 55, -1, -1, -1, -1, 0, 92, 1, 0, 1, 0};  // full on line 3, x 4..7
    tbl[3] = '{0, 1, -1, -1,  2,  4, -1, -1, 0, 95, 1, 1, 0, 0};  // short line + short period
    tbl[4] = '{0, 0, -1, -1, -1, -1, -1, -1, 0, 96, 1, 0, 0, 0};  // last armed frame
    tbl[5] = '{0, 1, -1, -1, -1, -1, -1, 10, 0,  0, 0, 0, 0, 1};  // unarmed, bad sync_n
    tbl[6] = '{0, 1, -1, -1, -1, -1, 56, -1, 0, 55, 0, 0, 0, 0};  // reset at (8,3)
    tbl[7] = '{0, 1, -1, -1, -1, -1, -1, -1, 0, 96, 1, 0, 0, 0};  // relock after reset

    rst = 1'b1; err_clr = 1'b0; capture_en = 1'b0; fifo_full = 1'b0;
    red = '0; green = '0; blue = '0;
    hsync = 1'b1; vsync = 1'b1; sync_n = 1'b0; blank_n = 1'b0;
    repeat (3) step();
    check("reset_state", 32'({fifo_wreq, locked, frame_done, err_timing, err_sync_n,
                              err_overflow, frame_count}), 32'd0);
    check("reset_wdata", 32'(fifo_wdata), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_row(tbl[i]);

    for (int i = 0; i < 12; i++) begin
      r = '{0, int'($urandom_range(1)), -1, -1, -1, -1, -1, -1, 1, 0, 0, 0, 0, 0};
      run_row(r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
